psum_acc: RTL and testbench
===========================

PSUM_ACC -- requirements
Module: psum_acc

Interface
REQ-001 The block SHALL have parameter col, default 8, the number of array columns (psum lanes per row).
REQ-002 The block SHALL have parameter bw, default 16, the signed psum width per lane.
REQ-003 The block SHALL have parameter depth, default 16, the number of output rows (nij) per tile.
REQ-004 Port clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  reset, synchronous, active-high.
REQ-006 Port start  input  1  single-cycle pulse that begins a tile; sampled only in IDLE.
REQ-007 Port acc_num  input  4  number of accumulation passes; sampled with start; 0 treated as 1.
REQ-008 Port in  input  bw*col  psum row from the output FIFO; lane i is bits [bw*(i+1)-1:bw*i].
REQ-009 Port i_valid  input  1  output FIFO has a complete row at its head.
REQ-010 Port rd  output  1  pop strobe to the output FIFO.
REQ-011 Port out  output  bw*col  ReLU'd accumulated row, same lane packing as in.
REQ-012 Port o_valid  output  1  out holds a valid row.
REQ-013 Port o_ready  input  1  downstream accepts out this cycle.
REQ-014 Port o_last  output  1  high with o_valid on row depth-1.
REQ-015 Port busy  output  1  high in any state other than IDLE.
REQ-016 Port done  output  1  one-cycle pulse when a tile completes.

Function
REQ-017 The FSM SHALL have states IDLE, ACC, DRAIN and DONE.
REQ-018 IDLE->ACC on start; pass counter and row address SHALL clear; acc_num is latched.
REQ-019 In ACC, rd SHALL equal i_valid (combinational, same cycle); in is captured on that edge; rd SHALL be 0 in all other states.
REQ-020 Each pop SHALL update buffer[addr], then advance addr; addr depth-1 SHALL wrap to 0 and increment the pass counter.
REQ-021 Pass 0 SHALL write in directly (no prior clear); later passes SHALL add in to buffer[addr] per lane, signed.
REQ-022 Each per-lane add SHALL saturate to the signed bw range: +2^(bw-1)-1 / -2^(bw-1).
REQ-023 ACC->DRAIN when the pop at addr depth-1 of the final pass (pass = latched acc_num-1) completes.
REQ-024 In DRAIN, rows 0..depth-1 SHALL be presented in order; o_valid=1 and out=ReLU(buffer[addr]) with negative lanes forced to 0.
REQ-025 The row SHALL advance only on o_valid&&o_ready; out SHALL hold stable while o_ready=0.
REQ-026 DRAIN->DONE on acceptance of row depth-1; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-027 start outside IDLE SHALL be ignored; i_valid outside ACC SHALL be ignored, with no pop.
REQ-028 i_valid low in ACC SHALL stall the block with no state change.
REQ-029 Read-to-out latency in DRAIN SHALL be zero cycles from the registered buffer output; bubbles SHALL NOT occur between accepted rows.

Reset
REQ-030 On reset, the FSM SHALL go to IDLE, and the pass counter, addr and latched acc_num SHALL clear.
REQ-031 While reset is asserted and on the cycle after, rd, o_valid, o_last, busy and done SHALL be 0, and out SHALL be 0.
REQ-032 Buffer contents SHALL NOT be reset; they are don't-care until rewritten by pass 0.
REQ-033 Reset mid-ACC or mid-DRAIN SHALL abort the tile with no done pulse.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the default col/bw/depth constants, and the saturating-add and ReLU functions.
REQ-035 Sub-module psum_buf SHALL be a depth x (bw*col) register file with 1 write port and 1 read port, read-during-write returning old data.

Verification
REQ-036 acc_num=1, depth rows of lane value 5 -> 16 outputs of all lanes 5, o_last on row 15, then done pulses once.
REQ-037 acc_num=3, lane values 100, -50 and 20 per pass -> out lanes 70; a run summing to -30 -> out lanes 0 (ReLU).
REQ-038 bw=16, acc_num=2, both passes 30000 -> out 32767; both passes -30000 -> 0 after ReLU, and the internal value reads -32768.
REQ-039 i_valid toggled randomly in ACC and o_ready held low for 3 cycles on row 7 -> rd only when i_valid; row 7 held stable; no row lost or duplicated.
REQ-040 Reset asserted on row 9 of pass 1 -> next cycle IDLE, all outputs 0, no done; a new start runs the tile correctly.
REQ-041 start pulsed during DRAIN -> ignored; rd stays 0 throughout DRAIN.

Source files
------------

// File: rtl/psum_acc_pkg.sv
// psum_acc_pkg: shared definitions for the partial-sum accumulator.
//   - default geometry constants (columns, lane width, rows per tile)
//   - FSM state encoding
//   - lane arithmetic helpers: saturating signed add and ReLU
//   - address-width helper shared by the top and the row buffer
// Lane helpers work on 32-bit signed containers so that a single function
// serves any lane width up to 31 bits; callers sign-extend into the
// container and truncate the result back to the lane width.
package psum_acc_pkg;

  localparam int COL_DEFAULT   = 8;
  localparam int BW_DEFAULT    = 16;
  localparam int DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of a row address; a single-row buffer still gets one bit.
  function automatic int addr_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  // Signed add of two sign-extended lanes, clamped to the signed range of
  // a w-bit lane. The 33-bit intermediate cannot overflow for w <= 31.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return 32'(s);
  endfunction

  // Negative lanes are forced to zero.
  function automatic logic signed [31:0] relu(input logic signed [31:0] a);
    return (a < 32'sd0) ? 32'sd0 : a;
  endfunction

endpackage

// File: rtl/psum_buf.sv
// psum_buf: depth x width row buffer, one write port and one registered
// read port. A read of the row being written in the same cycle returns the
// old contents. Contents are never reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write row address
//   wdata  in   write row data
//   raddr  in   read row address (sampled on the clock edge)
//   rdata  out  registered read data
module psum_buf
  import psum_acc_pkg::*;
#(
  parameter int depth = DEPTH_DEFAULT,
  parameter int width = BW_DEFAULT * COL_DEFAULT
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [addr_width(depth)-1:0] waddr,
  input  logic [width-1:0]             wdata,
  input  logic [addr_width(depth)-1:0] raddr,
  output logic [width-1:0]             rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/psum_acc.sv
// psum_acc: accumulates acc_num passes of depth psum rows (col signed lanes
// of bw bits each) popped from an output FIFO into a row buffer, then
// drains the buffer through ReLU with a valid/ready handshake.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   pulse that begins a tile (honoured only when idle)
//   acc_num  in   number of accumulation passes, latched with start, 0 -> 1
//   in       in   psum row from the FIFO, lane i at [bw*(i+1)-1:bw*i]
//   i_valid  in   FIFO has a row at its head
//   rd       out  FIFO pop strobe (combinational from i_valid while accumulating)
//   out      out  ReLU'd accumulated row, same lane packing as in
//   o_valid  out  out holds a valid row
//   o_ready  in   downstream accepts out this cycle
//   o_last   out  o_valid on the final row of the tile
//   busy     out  tile in progress
//   done     out  one-cycle pulse when a tile completes
module psum_acc
  import psum_acc_pkg::*;
#(
  parameter int col   = COL_DEFAULT,
  parameter int bw    = BW_DEFAULT,
  parameter int depth = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        acc_num,
  input  logic [bw*col-1:0] in,
  input  logic              i_valid,
  output logic              rd,
  output logic [bw*col-1:0] out,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              o_last,
  output logic              busy,
  output logic              done
);

  localparam int aw = addr_width(depth);

  state_t            state_reg;
  logic [aw-1:0]     addr_reg;
  logic [3:0]        pass_reg;
  logic [3:0]        acc_lat_reg;

  logic [aw-1:0]     addr_inc;
  logic [aw-1:0]     raddr;
  logic              at_end;
  logic              last_pass;
  logic              step;
  logic [bw*col-1:0] rd_data;
  logic [bw*col-1:0] wr_data;

  assign at_end    = (addr_reg == aw'(depth - 1));
  assign addr_inc  = at_end ? '0 : addr_reg + aw'(1);
  assign last_pass = (pass_reg == acc_lat_reg - 4'd1);

  // Outputs are decoded from the state register and masked by reset so
  // they read zero during reset as well as on the cycle after.
  assign rd      = !reset && (state_reg == ACC) && i_valid;
  assign o_valid = !reset && (state_reg == DRAIN);
  assign o_last  = o_valid && at_end;
  assign busy    = !reset && (state_reg != IDLE);
  assign done    = !reset && (state_reg == DONE);

  // The buffer read port always looks one row ahead: when the row address
  // is about to advance, fetch the next row so its registered data is
  // ready the cycle the address lands on it. This gives the
  // read-modify-write in ACC its old value and lets DRAIN present a new
  // row every accepted cycle without bubbles.
  assign step  = rd || (o_valid && o_ready);
  assign raddr = step ? addr_inc : addr_reg;

  for (genvar gi = 0; gi < col; gi++) begin : g_lane
    logic [bw-1:0] lane_in;
    logic [bw-1:0] lane_old;

    assign lane_in  = in[bw*gi +: bw];
    assign lane_old = rd_data[bw*gi +: bw];

    // Pass 0 overwrites whatever the buffer held from a previous tile.
    assign wr_data[bw*gi +: bw] = (pass_reg == 4'd0) ? lane_in :
        bw'(sat_add(32'($signed(lane_in)), 32'($signed(lane_old)), bw));

    assign out[bw*gi +: bw] = o_valid ? bw'(relu(32'($signed(lane_old)))) : '0;
  end

  psum_buf #(
    .depth (depth),
    .width (bw * col)
  ) u_buf (
    .clk   (clk),
    .we    (rd),
    .waddr (addr_reg),
    .wdata (wr_data),
    .raddr (raddr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      pass_reg    <= '0;
      addr_reg    <= '0;
      acc_lat_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= ACC;
            pass_reg    <= '0;
            addr_reg    <= '0;
            acc_lat_reg <= (acc_num == 4'd0) ? 4'd1 : acc_num;
          end
        end
        ACC: begin
          if (i_valid) begin
            addr_reg <= addr_inc;
            if (at_end) begin
              if (last_pass) begin
                state_reg <= DRAIN;
                pass_reg  <= '0;
              end else begin
                pass_reg <= pass_reg + 4'd1;
              end
            end
          end
        end
        DRAIN: begin
          if (o_ready) begin
            addr_reg <= addr_inc;
            if (at_end) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_acc.sv
// tb_psum_acc: self-checking bench for psum_acc with default geometry
// (8 lanes of 16 bits, 16 rows). A table of uniform-lane tiles with
// hand-computed results is run first, then random tiles with FIFO bubbles,
// a drain stall, a start pulse during drain, and a mid-accumulation reset.
// Expected drain rows go into a queue when the tile's rows are driven and
// are popped as the DUT presents accepted rows.
module tb_psum_acc;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;
  localparam int W     = BW * COL;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   acc_num;
  logic [W-1:0] in;
  logic         i_valid;
  logic         rd;
  logic [W-1:0] out;
  logic         o_valid;
  logic         o_ready;
  logic         o_last;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  psum_acc #(
    .col   (COL),
    .bw    (BW),
    .depth (DEPTH)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .acc_num (acc_num),
    .in      (in),
    .i_valid (i_valid),
    .rd      (rd),
    .out     (out),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_last  (o_last),
    .busy    (busy),
    .done    (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q [$];
  int           mdl [DEPTH][COL];

  typedef struct {
    int acc;
    int v0;
    int v1;
    int v2;
    int exp_lane;
  } vec_t;

  vec_t vecs [7];

  task automatic chk_i(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  function automatic int sat(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic logic [W-1:0] rep(input int v);
    logic [W-1:0] r;
    for (int l = 0; l < COL; l++) r[BW*l +: BW] = 16'(v);
    return r;
  endfunction

  task automatic do_start(input int acc);
    start   = 1'b1;
    acc_num = 4'(acc);
    @(negedge clk);
    start = 1'b0;
    #1 chk_i("busy_after_start", int'(busy), 1);
  endtask

  // Present one row; with rnd, precede it by 0..2 bubble cycles carrying
  // garbage data that must not be popped.
  task automatic feed_row(input logic [W-1:0] row, input bit rnd);
    if (rnd) begin
      int gaps = int'($urandom_range(0, 2));
      for (int k = 0; k < gaps; k++) begin
        in      = ~row;
        i_valid = 1'b0;
        #1 chk_i("rd_in_bubble", int'(rd), 0);
        @(negedge clk);
      end
    end
    in      = row;
    i_valid = 1'b1;
    #1 chk_i("rd_on_valid", int'(rd), 1);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic drain(input int stall_row, input int stall_n, input bit poke_start);
    int row  = 0;
    int held = 0;
    while (row < DEPTH) begin
      o_ready = !(row == stall_row && held < stall_n);
      i_valid = 1'($urandom_range(0, 1));
      start   = poke_start && (row == 3);
      #1;
      chk_i("drain_valid_no_rd", int'({o_valid, rd}), 2);
      if (o_ready) begin
        chk_w($sformatf("out_row%0d", row), out, exp_q.pop_front());
        chk_i($sformatf("o_last_row%0d", row), int'(o_last), int'(row == DEPTH - 1));
        row++;
      end else begin
        chk_w($sformatf("out_held_row%0d", row), out, exp_q[0]);
        held++;
      end
      @(negedge clk);
    end
    start   = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    #1 chk_i("done_pulse", int'({done, busy, o_valid}), 6);
    @(negedge clk);
    #1 chk_i("back_to_idle", int'({done, busy, o_valid}), 0);
    @(negedge clk);
  endtask

  task automatic run_tile(input int acc, input int v0, input int v1, input int v2,
                          input bit rnd, input int exp_lane,
                          input int stall_row, input int stall_n, input bit poke_start);
    int eff = (acc == 0) ? 1 : acc;
    do_start(acc);
    for (int p = 0; p < eff; p++) begin
      for (int r = 0; r < DEPTH; r++) begin
        logic [W-1:0] row;
        for (int l = 0; l < COL; l++) begin
          int val;
          if (rnd) val = int'($urandom_range(0, 40000)) - 20000;
          else     val = (p == 0) ? v0 : (p == 1) ? v1 : v2;
          mdl[r][l] = (p == 0) ? val : sat(mdl[r][l] + val);
          row[BW*l +: BW] = 16'(val);
        end
        feed_row(row, rnd);
      end
    end
    for (int r = 0; r < DEPTH; r++) begin
      logic [W-1:0] e;
      for (int l = 0; l < COL; l++) e[BW*l +: BW] = 16'((mdl[r][l] < 0) ? 0 : mdl[r][l]);
      exp_q.push_back(rnd ? e : rep(exp_lane));
    end
    $display("tile acc_num=%0d random=%0d rows_queued=%0d", acc, rnd, exp_q.size());
    drain(stall_row, stall_n, poke_start);
  endtask

  initial begin
    vecs[0] = '{acc: 1, v0: 5,      v1: 0,      v2: 0,  exp_lane: 5};
    vecs[1] = '{acc: 3, v0: 100,    v1: -50,    v2: 20, exp_lane: 70};
    vecs[2] = '{acc: 3, v0: -10,    v1: -30,    v2: 10, exp_lane: 0};
    vecs[3] = '{acc: 2, v0: 30000,  v1: 30000,  v2: 0,  exp_lane: 32767};
    vecs[4] = '{acc: 2, v0: -30000, v1: -30000, v2: 0,  exp_lane: 0};
    vecs[5] = '{acc: 0, v0: 7,      v1: 0,      v2: 0,  exp_lane: 7};
    vecs[6] = '{acc: 2, v0: -32768, v1: -1,     v2: 0,  exp_lane: 0};

    reset   = 1'b1;
    start   = 1'b0;
    acc_num = 4'd0;
    in      = '0;
    i_valid = 1'b0;
    o_ready = 1'b0;

    // Outputs low while reset is held (with active-looking inputs) and on
    // the cycle after.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_valid = 1'b1;
      #1 chk_i("reset_ctrl", int'({rd, o_valid, o_last, busy, done}), 0);
      chk_w("reset_out", out, '0);
    end
    @(negedge clk);
    reset   = 1'b0;
    i_valid = 1'b0;
    #1 chk_i("post_reset_ctrl", int'({rd, o_valid, o_last, busy, done}), 0);
    chk_w("post_reset_out", out, '0);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_tile(vecs[i].acc, vecs[i].v0, vecs[i].v1, vecs[i].v2, 1'b0,
               vecs[i].exp_lane, -1, 0, 1'b0);
      if (i == 4) begin
        chk_i("internal_sat_min_row0", int'($signed(u_dut.u_buf.mem[0][15:0])), -32768);
        chk_i("internal_sat_min_row15", int'($signed(u_dut.u_buf.mem[15][127:112])), -32768);
      end
    end

    // Random data with FIFO bubbles, drain stalled 3 cycles on row 7.
    run_tile(2, 0, 0, 0, 1'b1, 0, 7, 3, 1'b0);
    // Random 3-pass tile with a start pulse during drain.
    run_tile(3, 0, 0, 0, 1'b1, 0, -1, 0, 1'b1);

    // Reset on row 9 of pass 1 aborts the tile with no done.
    do_start(2);
    for (int r = 0; r < DEPTH; r++) feed_row(rep(1), 1'b0);
    for (int r = 0; r < 9; r++) feed_row(rep(2), 1'b0);
    reset   = 1'b1;
    i_valid = 1'b1;
    in      = rep(3);
    #1 chk_i("midacc_reset_ctrl", int'({rd, o_valid, o_last, busy, done}), 0);
    chk_w("midacc_reset_out", out, '0);
    @(negedge clk);
    reset   = 1'b0;
    i_valid = 1'b0;
    #1 chk_i("after_abort_ctrl", int'({rd, o_valid, o_last, busy, done}), 0);
    chk_w("after_abort_out", out, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk_i("no_done_after_abort", int'({done, busy}), 0);
    end
    @(negedge clk);
    run_tile(2, 0, 0, 0, 1'b1, 0, -1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
